// File: rtl/ir_sensor_acq_if.sv
// A2D conversion handshake: the acquisition block is the master and the converter is the slave.
interface ir_sensor_acq_if;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;

    modport master (
        output strt_cnv,
        output chnnl,
        input  cnv_cmplt,
        input  res
    );

    modport slave (
        input  strt_cnv,
        input  chnnl,
        output cnv_cmplt,
        output res
    );
endinterface

// File: rtl/ir_sensor_acq.sv
// IR wall-sensor acquisition: periodic emitter sweep, left/right A2D sequencing, opening flags and derivative term.
// Optional rounding average of each reading with the previously published value when IR_FILT_EN is defined.
module ir_sensor_acq #(
    parameter logic [15:0] PERIOD     = 16'd50000,
    parameter logic [7:0]  SETTLE     = 8'd100,
    parameter logic [2:0]  LFT_CHNNL  = 3'd3,
    parameter logic [2:0]  RGHT_CHNNL = 3'd0,
    parameter logic [11:0] NOM_IR     = 12'h970,
    parameter logic [11:0] OPN_THRESH = 12'h300
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ir_sensor_acq_if.master       a2d,
    output logic                  IR_en,
    output logic [11:0]           lft_IR,
    output logic [11:0]           rght_IR,
    output logic                  lft_opn,
    output logic                  rght_opn,
    output logic [8:0]            IR_Dtrm,
    output logic                  vld
);

    localparam int unsigned RES_W  = 12;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned SET_W  = 8;
    localparam int unsigned CH_W   = 3;
    localparam int unsigned DTRM_W = 9;
    localparam int unsigned ERR_W  = 13;
    localparam int unsigned DIFF_W = 14;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_WAIT_L,
        S_WAIT_R,
        S_UPDATE
    } state_t;

    state_t                    state_q,    state_d;
    logic [CNT_W-1:0]          per_cnt_q,  per_cnt_d;
    logic [SET_W-1:0]          set_cnt_q,  set_cnt_d;
    logic                      ir_en_q,    ir_en_d;
    logic                      strt_cnv_q, strt_cnv_d;
    logic [CH_W-1:0]           chnnl_q,    chnnl_d;
    logic [RES_W-1:0]          lft_raw_q,  lft_raw_d;
    logic [RES_W-1:0]          rght_raw_q, rght_raw_d;
    logic [RES_W-1:0]          lft_ir_q,   lft_ir_d;
    logic [RES_W-1:0]          rght_ir_q,  rght_ir_d;
    logic                      lft_opn_q,  lft_opn_d;
    logic                      rght_opn_q, rght_opn_d;
    logic [DTRM_W-1:0]         dtrm_q,     dtrm_d;
    logic signed [ERR_W-1:0]   prev_err_q, prev_err_d;
    logic                      vld_q,      vld_d;

    logic                      tick_c;
    logic [RES_W-1:0]          lft_smp_c;
    logic [RES_W-1:0]          rght_smp_c;
    logic signed [ERR_W-1:0]   err_c;
    logic signed [DIFF_W-1:0]  diff_c;
    logic [DTRM_W-1:0]         sat_c;
    logic                      any_opn_c;

`ifdef IR_FILT_EN
    // Rounded mean of the published reading and the new sample; 13-bit sum avoids overflow.
    function automatic logic [RES_W-1:0] filt(input logic [RES_W-1:0] old_v, input logic [RES_W-1:0] smp);
        return RES_W'((ERR_W'(old_v) + ERR_W'(smp) + ERR_W'(1)) >> 1);
    endfunction

    assign lft_smp_c  = filt(lft_ir_q, a2d.res);
    assign rght_smp_c = filt(rght_ir_q, a2d.res);
`else
    assign lft_smp_c  = a2d.res;
    assign rght_smp_c = a2d.res;
`endif

    assign tick_c = (per_cnt_q == PERIOD - 16'd1);

    // Opening flags, error and saturated derivative from the stored readings.
    always_comb begin
        any_opn_c = (lft_raw_q < OPN_THRESH) || (rght_raw_q < OPN_THRESH);
        err_c     = $signed({1'b0, lft_raw_q}) - $signed({1'b0, rght_raw_q});
        diff_c    = $signed({err_c[ERR_W-1], err_c}) - $signed({prev_err_q[ERR_W-1], prev_err_q});
        if (diff_c > 14'sd255) begin
            sat_c = 9'h0FF;
        end else if (diff_c < -14'sd256) begin
            sat_c = 9'h100;
        end else begin
            sat_c = diff_c[DTRM_W-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        per_cnt_d  = tick_c ? '0 : per_cnt_q + 16'd1;
        set_cnt_d  = set_cnt_q;
        ir_en_d    = ir_en_q;
        strt_cnv_d = 1'b0;
        chnnl_d    = chnnl_q;
        lft_raw_d  = lft_raw_q;
        rght_raw_d = rght_raw_q;
        lft_ir_d   = lft_ir_q;
        rght_ir_d  = rght_ir_q;
        lft_opn_d  = lft_opn_q;
        rght_opn_d = rght_opn_q;
        dtrm_d     = dtrm_q;
        prev_err_d = prev_err_q;
        vld_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (tick_c) begin
                    state_d   = S_SETTLE;
                    ir_en_d   = 1'b1;
                    set_cnt_d = '0;
                end
            end
            S_SETTLE: begin
                if (set_cnt_q == SETTLE - 8'd1) begin
                    strt_cnv_d = 1'b1;
                    chnnl_d    = LFT_CHNNL;
                    state_d    = S_WAIT_L;
                end else begin
                    set_cnt_d = set_cnt_q + 8'd1;
                end
            end
            S_WAIT_L: begin
                if (a2d.cnv_cmplt) begin
                    lft_raw_d  = lft_smp_c;
                    strt_cnv_d = 1'b1;
                    chnnl_d    = RGHT_CHNNL;
                    state_d    = S_WAIT_R;
                end
            end
            S_WAIT_R: begin
                if (a2d.cnv_cmplt) begin
                    rght_raw_d = rght_smp_c;
                    state_d    = S_UPDATE;
                end
            end
            S_UPDATE: begin
                lft_ir_d   = lft_raw_q;
                rght_ir_d  = rght_raw_q;
                lft_opn_d  = (lft_raw_q < OPN_THRESH);
                rght_opn_d = (rght_raw_q < OPN_THRESH);
                dtrm_d     = any_opn_c ? '0 : sat_c;
                prev_err_d = any_opn_c ? '0 : err_c;
                vld_d      = 1'b1;
                ir_en_d    = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            per_cnt_q  <= '0;
            set_cnt_q  <= '0;
            ir_en_q    <= 1'b0;
            strt_cnv_q <= 1'b0;
            chnnl_q    <= '0;
            lft_raw_q  <= NOM_IR;
            rght_raw_q <= NOM_IR;
            lft_ir_q   <= NOM_IR;
            rght_ir_q  <= NOM_IR;
            lft_opn_q  <= 1'b0;
            rght_opn_q <= 1'b0;
            dtrm_q     <= '0;
            prev_err_q <= '0;
            vld_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            per_cnt_q  <= per_cnt_d;
            set_cnt_q  <= set_cnt_d;
            ir_en_q    <= ir_en_d;
            strt_cnv_q <= strt_cnv_d;
            chnnl_q    <= chnnl_d;
            lft_raw_q  <= lft_raw_d;
            rght_raw_q <= rght_raw_d;
            lft_ir_q   <= lft_ir_d;
            rght_ir_q  <= rght_ir_d;
            lft_opn_q  <= lft_opn_d;
            rght_opn_q <= rght_opn_d;
            dtrm_q     <= dtrm_d;
            prev_err_q <= prev_err_d;
            vld_q      <= vld_d;
        end
    end

    assign a2d.strt_cnv = strt_cnv_q;
    assign a2d.chnnl    = chnnl_q;
    assign IR_en        = ir_en_q;
    assign lft_IR       = lft_ir_q;
    assign rght_IR      = rght_ir_q;
    assign lft_opn      = lft_opn_q;
    assign rght_opn     = rght_opn_q;
    assign IR_Dtrm      = dtrm_q;
    assign vld          = vld_q;

endmodule

// File: tb/tb_ir_sensor_acq.sv
// Directed bench for ir_sensor_acq with a short sweep period; plays the A2D side of the handshake.
module tb_ir_sensor_acq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        IR_en;
    logic [11:0] lft_IR;
    logic [11:0] rght_IR;
    logic        lft_opn;
    logic        rght_opn;
    logic [8:0]  IR_Dtrm;
    logic        vld;

    int n_run  = 0;
    int n_fail = 0;

    ir_sensor_acq_if a2d_if ();

    ir_sensor_acq #(
        .PERIOD (16'd200),
        .SETTLE (8'd10)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a2d      (a2d_if),
        .IR_en    (IR_en),
        .lft_IR   (lft_IR),
        .rght_IR  (rght_IR),
        .lft_opn  (lft_opn),
        .rght_opn (rght_opn),
        .IR_Dtrm  (IR_Dtrm),
        .vld      (vld)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] l;
        logic [11:0] r;
        logic [11:0] exp_l;
        logic [11:0] exp_r;
        logic        exp_lo;
        logic        exp_ro;
        logic [8:0]  exp_d;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_run++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_strt(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step(1);
            if (a2d_if.strt_cnv) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_run++;
            n_fail++;
            $display("FAIL %s: strt_cnv not seen within 400 cycles", tag);
        end
    endtask

    // One full sweep from the left strt_cnv to the vld pulse, checking every handshake step.
    task automatic run_sweep(input logic [11:0] l, input logic [11:0] r, input int lat,
                             input bit started, input logic [11:0] el, input logic [11:0] er,
                             input logic elo, input logic ero, input logic [8:0] ed, input string tag);
        bit ok;
        int extra;
        if (!started) begin
            wait_strt(tag, ok);
            if (!ok) return;
        end
        chk({tag, " left chnnl"}, 32'(a2d_if.chnnl), 32'd3);
        chk({tag, " IR_en on"}, 32'(IR_en), 32'd1);
        extra = 0;
        for (int i = 0; i < lat; i++) begin
            step(1);
            if (a2d_if.strt_cnv) extra++;
        end
        chk({tag, " extra strt_cnv"}, 32'(extra), 32'd0);
        chk({tag, " chnnl held L"}, 32'(a2d_if.chnnl), 32'd3);
        a2d_if.cnv_cmplt = 1'b1;
        a2d_if.res       = l;
        step(1);
        a2d_if.cnv_cmplt = 1'b0;
        a2d_if.res       = 12'h000;
        chk({tag, " right strt_cnv"}, 32'(a2d_if.strt_cnv), 32'd1);
        chk({tag, " right chnnl"}, 32'(a2d_if.chnnl), 32'd0);
        step(2);
        chk({tag, " strt_cnv pulse"}, 32'(a2d_if.strt_cnv), 32'd0);
        a2d_if.cnv_cmplt = 1'b1;
        a2d_if.res       = r;
        step(1);
        a2d_if.cnv_cmplt = 1'b0;
        a2d_if.res       = 12'h000;
        chk({tag, " vld early"}, 32'(vld), 32'd0);
        step(1);
        chk({tag, " vld"}, 32'(vld), 32'd1);
        chk({tag, " IR_en off"}, 32'(IR_en), 32'd0);
        chk({tag, " lft_IR"}, 32'(lft_IR), 32'(el));
        chk({tag, " rght_IR"}, 32'(rght_IR), 32'(er));
        chk({tag, " lft_opn"}, 32'(lft_opn), 32'(elo));
        chk({tag, " rght_opn"}, 32'(rght_opn), 32'(ero));
        chk({tag, " IR_Dtrm"}, 32'(IR_Dtrm), 32'(ed));
        step(1);
        chk({tag, " vld one-shot"}, 32'(vld), 32'd0);
        chk({tag, " IR_Dtrm hold"}, 32'(IR_Dtrm), 32'(ed));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        vecs[0] = '{12'h9A0, 12'h940, 12'h9A0, 12'h940, 1'b0, 1'b0, 9'h060};
        vecs[1] = '{12'h200, 12'h970, 12'h200, 12'h970, 1'b1, 1'b0, 9'h000};
        vecs[2] = '{12'h9A0, 12'h940, 12'h9A0, 12'h940, 1'b0, 1'b0, 9'h060};
        vecs[3] = '{12'h300, 12'hB00, 12'h300, 12'hB00, 1'b0, 1'b0, 9'h100};
        vecs[4] = '{12'hB00, 12'h300, 12'hB00, 12'h300, 1'b0, 1'b0, 9'h0FF};
        vecs[5] = '{12'h300, 12'hB00, 12'h300, 12'hB00, 1'b0, 1'b0, 9'h100};
        vecs[6] = '{12'h2FF, 12'h2FF, 12'h2FF, 12'h2FF, 1'b1, 1'b1, 9'h000};
        vecs[7] = '{12'h300, 12'h300, 12'h300, 12'h300, 1'b0, 1'b0, 9'h000};
        vecs[8] = '{12'h950, 12'h940, 12'h950, 12'h940, 1'b0, 1'b0, 9'h010};
        vecs[9] = '{12'h940, 12'h950, 12'h940, 12'h950, 1'b0, 1'b0, 9'h1E0};

        rst_n            = 1'b0;
        a2d_if.cnv_cmplt = 1'b0;
        a2d_if.res       = 12'h000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        chk("reset lft_IR", 32'(lft_IR), 32'h970);
        chk("reset rght_IR", 32'(rght_IR), 32'h970);
        chk("reset opn", 32'({lft_opn, rght_opn}), 32'd0);
        chk("reset IR_Dtrm", 32'(IR_Dtrm), 32'd0);
        chk("reset ctl", 32'({IR_en, a2d_if.strt_cnv, vld}), 32'd0);
        chk("reset chnnl", 32'(a2d_if.chnnl), 32'd0);

        step(199);
        chk("IR_en before tick", 32'(IR_en), 32'd0);
        step(1);
        chk("IR_en at 200", 32'(IR_en), 32'd1);
        step(9);
        chk("strt_cnv before 210", 32'(a2d_if.strt_cnv), 32'd0);
        step(1);
        chk("strt_cnv at 210", 32'(a2d_if.strt_cnv), 32'd1);

`ifdef IR_FILT_EN
        run_sweep(12'hA70, 12'h970, 2, 1'b1, 12'h9F0, 12'h970, 1'b0, 1'b0, 9'h080, "filt");
`else
        for (int i = 0; i < 10; i++) begin
            run_sweep(vecs[i].l, vecs[i].r, 2, (i == 0), vecs[i].exp_l, vecs[i].exp_r,
                      vecs[i].exp_lo, vecs[i].exp_ro, vecs[i].exp_d, $sformatf("vec%0d", i));
        end

        // Left conversion stalls past the next tick: no new sweep may start.
        run_sweep(12'h9A0, 12'h940, 250, 1'b0, 12'h9A0, 12'h940, 1'b0, 1'b0, 9'h070, "stall");

        // Reset while waiting for the right sample.
        wait_strt("rst", ok);
        if (ok) begin
            a2d_if.cnv_cmplt = 1'b1;
            a2d_if.res       = 12'h123;
            step(1);
            a2d_if.cnv_cmplt = 1'b0;
            step(1);
            rst_n = 1'b0;
            step(1);
            chk("mid rst lft_IR", 32'(lft_IR), 32'h970);
            chk("mid rst rght_IR", 32'(rght_IR), 32'h970);
            chk("mid rst opn", 32'({lft_opn, rght_opn}), 32'd0);
            chk("mid rst IR_Dtrm", 32'(IR_Dtrm), 32'd0);
            chk("mid rst ctl", 32'({IR_en, a2d_if.strt_cnv, vld}), 32'd0);
            chk("mid rst chnnl", 32'(a2d_if.chnnl), 32'd0);
            rst_n = 1'b1;
            run_sweep(12'h9A0, 12'h940, 2, 1'b0, 12'h9A0, 12'h940, 1'b0, 1'b0, 9'h060, "post rst");
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
